div_unit: RTL and testbench

Multi-cycle iterative divider that executes DIV/DIVU for the MIPS core and returns the {HI, LO} pair.
- The execute stage launches it and stalls on `busy_o`, then captures `result_o` into the HI/LO registers when `ready_o` rises.
- It is the sequential counterpart to the single-cycle ALU, which has no path to HI/LO.
- Radix-2 restoring division: one quotient bit per cycle, then sign correction.

---
 rtl/div_unit_if.sv | 25 ++
 rtl/div_unit.sv | 168 ++++++++++++++++
 tb/tb_div_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the EX stage and div_unit.
//   master (EX stage): drives start_i, signed_i, opa_i, opb_i, annul_i
//   slave  (div_unit): drives result_o {HI, LO}, ready_o, busy_o
interface div_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  start_i;
    logic                  signed_i;
    logic [DATA_W-1:0]     opa_i;
    logic [DATA_W-1:0]     opb_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output start_i, signed_i, opa_i, opb_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, signed_i, opa_i, opb_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {remainder (HI), quotient (LO)} after DATA_W iterations plus
// sign correction; the result is held while start_i stays high.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor short-circuits
// through the DZERO state (2-cycle latency) instead of iterating.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - div_unit_if.slave: start_i, signed_i, opa_i, opb_i, annul_i in;
//          result_o, ready_o, busy_o out (busy_o is combinational)
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int unsigned CNT_W = 6;
    localparam int unsigned REM_W = DATA_W + 1;
    localparam int unsigned SR_W  = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef DIV_ZERO_FAST_EN
        DZERO = 2'd1,
`endif
        ON    = 2'd2,
        END   = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_W-1:0]     mag_b;
    logic                  quo_neg;
    logic                  rem_neg;
    logic [CNT_W-1:0]      cnt;
    logic [SR_W-1:0]       sr;
    logic                  ready;
    logic [2*DATA_W-1:0]   result;

    logic                  in_a_neg;
    logic                  in_b_neg;
    logic [DATA_W-1:0]     in_mag_a;
    logic [DATA_W-1:0]     in_mag_b;
    logic [SR_W-1:0]       shifted;
    logic [REM_W-1:0]      trial;
    logic [SR_W-1:0]       step_sr;
    logic [DATA_W-1:0]     fin_rem;
    logic [DATA_W-1:0]     fin_quo;
    logic [DATA_W-1:0]     cor_rem;
    logic [DATA_W-1:0]     cor_quo;
    logic                  busy;

    // The remainder never exceeds DATA_W bits, so the register MSB is
    // always shifted out as zero.
    logic                  unused_sr_msb;
    assign unused_sr_msb = sr[SR_W-1];

    // Operand magnitudes for the IDLE sample.
    always_comb begin
        in_a_neg = bus.signed_i & bus.opa_i[DATA_W-1];
        in_b_neg = bus.signed_i & bus.opb_i[DATA_W-1];
        in_mag_a = in_a_neg ? DATA_W'((~bus.opa_i) + DATA_W'(1)) : bus.opa_i;
        in_mag_b = in_b_neg ? DATA_W'((~bus.opb_i) + DATA_W'(1)) : bus.opb_i;
    end

    // One restoring step plus the sign-corrected final result.
    always_comb begin
        shifted = {sr[SR_W-2:0], 1'b0};
        trial   = shifted[SR_W-1:DATA_W] - {1'b0, mag_b};
        step_sr = shifted;
        // A clear MSB on the (DATA_W+1)-bit trial means the subtraction fits.
        if (!trial[DATA_W]) begin
            step_sr[SR_W-1:DATA_W] = trial;
            step_sr[0]             = 1'b1;
        end

        fin_rem = step_sr[SR_W-2:DATA_W];
        fin_quo = step_sr[DATA_W-1:0];
`ifdef DIV_ZERO_FAST_EN
        // In DZERO the low half still holds |a| from the IDLE load.
        if (state == DZERO) begin
            fin_rem = sr[DATA_W-1:0];
            fin_quo = '1;
        end
`endif
        cor_rem = rem_neg ? DATA_W'((~fin_rem) + DATA_W'(1)) : fin_rem;
        cor_quo = quo_neg ? DATA_W'((~fin_quo) + DATA_W'(1)) : fin_quo;
    end

    // Stall request back to EX.
    always_comb begin
        busy = (state == ON) || ((state == IDLE) && bus.start_i);
`ifdef DIV_ZERO_FAST_EN
        if (state == DZERO) begin
            busy = 1'b1;
        end
`endif
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mag_b   <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            cnt     <= '0;
            sr      <= '0;
            ready   <= 1'b0;
            result  <= '0;
        end else if (bus.annul_i) begin
            state  <= IDLE;
            cnt    <= '0;
            ready  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        mag_b   <= in_mag_b;
                        quo_neg <= bus.signed_i &
                                   (bus.opa_i[DATA_W-1] ^ bus.opb_i[DATA_W-1]);
                        rem_neg <= in_a_neg;
                        sr      <= {{REM_W{1'b0}}, in_mag_a};
                        cnt     <= '0;
`ifdef DIV_ZERO_FAST_EN
                        state   <= (bus.opb_i == '0) ? DZERO : ON;
`else
                        state   <= ON;
`endif
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                DZERO: begin
                    state  <= END;
                    ready  <= 1'b1;
                    result <= {cor_rem, cor_quo};
                end
`endif
                ON: begin
                    sr  <= step_sr;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state  <= END;
                        ready  <= 1'b1;
                        result <= {cor_rem, cor_quo};
                    end
                end
                END: begin
                    if (!bus.start_i) begin
                        state  <= IDLE;
                        ready  <= 1'b0;
                        result <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ready  <= 1'b0;
                    result <= '0;
                end
            endcase
        end
    end

    assign bus.ready_o  = ready;
    assign bus.result_o = result;
    assign bus.busy_o   = busy;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit (DATA_W = 32).
// Directed vector table, random operations against an arithmetic reference
// model, and hand-written annul / reset / hold sequences.
module tb_div_unit;
    localparam int unsigned W = 32;
    localparam int NORM_LAT = 33;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 33;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_unit_if #(.DATA_W(W)) bus ();

    div_unit #(.DATA_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics from plain integer arithmetic.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [31:0] qq;
        logic [31:0] rr;
        if (b == 32'd0) begin
            rr = a;
            qq = (sgn && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            qq = q[31:0];
            rr = r[31:0];
        end else begin
            qq = a / b;
            rr = a % b;
        end
        return {rr, qq};
    endfunction

    // Launch one operation, wait for ready, check latency/result/handshake.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp, input int hold);
        int          n;
        int          lat;
        logic        busy_bad;
        logic        stable_bad;
        logic [63:0] held;
        lat = (b == 32'd0) ? ZERO_LAT : NORM_LAT;
        bus.start_i  = 1'b1;
        bus.signed_i = sgn;
        bus.opa_i    = a;
        bus.opb_i    = b;
        #1;
        check({name, "_busy_idle"}, 64'(bus.busy_o), 64'd1);
        n        = 0;
        busy_bad = 1'b0;
        while (!bus.ready_o && n < 100) begin
            tick();
            n++;
            if (n == 1) begin
                bus.opa_i = $urandom;
                bus.opb_i = $urandom;
            end
            if (!bus.ready_o && !bus.busy_o) busy_bad = 1'b1;
        end
        check({name, "_latency"}, 64'(n), 64'(lat));
        check({name, "_result"}, bus.result_o, exp);
        check({name, "_busy_run"}, 64'(busy_bad), 64'd0);
        check({name, "_busy_end"}, 64'(bus.busy_o), 64'd0);
        held       = bus.result_o;
        stable_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.ready_o !== 1'b1 || bus.result_o !== held) stable_bad = 1'b1;
        end
        if (hold > 0) check({name, "_hold"}, 64'(stable_bad), 64'd0);
        bus.start_i = 1'b0;
        tick();
        check({name, "_ready_drop"}, 64'(bus.ready_o), 64'd0);
        check({name, "_result_clear"}, bus.result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        rose;
        checks = 0;
        errors = 0;

        vecs[0]  = '{32'd100,       32'd7,         1'b0, {32'h0000_0002, 32'h0000_000E}, 5};
        vecs[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0};
        vecs[2]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 0};
        vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 0};
        vecs[4]  = '{32'd5,         32'd0,         1'b0, {32'h0000_0005, 32'hFFFF_FFFF}, 0};
        vecs[5]  = '{32'hFFFF_FFFB, 32'd0,         1'b1, {32'hFFFF_FFFB, 32'h0000_0001}, 1};
        vecs[6]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 0};
        vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'h0000_0000, 32'h0000_0001}, 0};
        vecs[8]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000}, 0};
        vecs[9]  = '{32'd5,         32'd0,         1'b1, {32'h0000_0005, 32'hFFFF_FFFF}, 0};
        vecs[10] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 2};

        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.opa_i    = '0;
        bus.opb_i    = '0;
        bus.annul_i  = 1'b0;
        tick();
        tick();
        tick();
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_result", bus.result_o, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
                   vecs[i].exp, vecs[i].hold);
        end

        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(1, 255));
                1:       b = 32'd0;
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), a, b, sgn, ref_div(a, b, sgn),
                   $urandom_range(0, 2));
        end

        // Annul during ON: pulsed at T+10, IDLE at T+11, no result ever.
        bus.start_i  = 1'b1;
        bus.signed_i = 1'b0;
        bus.opa_i    = 32'd1000;
        bus.opb_i    = 32'd3;
        tick();
        for (int i = 0; i < 9; i++) tick();
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        tick();
        bus.annul_i = 1'b0;
        check("annul_ready", 64'(bus.ready_o), 64'd0);
        check("annul_result", bus.result_o, 64'd0);
        check("annul_busy", 64'(bus.busy_o), 64'd0);
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ready_o) rose = 1'b1;
        end
        check("annul_no_ready", 64'(rose), 64'd0);
        run_op("after_annul", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 0);

        // Reset in the middle of ON discards everything.
        bus.start_i  = 1'b1;
        bus.signed_i = 1'b1;
        bus.opa_i    = 32'hDEAD_BEEF;
        bus.opb_i    = 32'h0000_1234;
        for (int i = 0; i < 10; i++) tick();
        rst         = 1'b1;
        bus.start_i = 1'b0;
        tick();
        check("midrst_ready", 64'(bus.ready_o), 64'd0);
        check("midrst_result", bus.result_o, 64'd0);
        check("midrst_busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;
        tick();
        run_op("after_rst", 32'hDEAD_BEEF, 32'h0000_1234, 1'b1,
               ref_div(32'hDEAD_BEEF, 32'h0000_1234, 1'b1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
